data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data word width.
REQ-002 SHALL have parameter MEM_ADDRESS_WIDTH, default 9, byte address width (2^9 = 512 bytes of storage).
REQ-003 SHALL have parameter LATENCY, default 2, cycles from request acceptance to response; legal range 1..15.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-006 SHALL have port req_valid  input  1  initiator presents a load/store request.
REQ-007 SHALL have port req_ready  output  1  responder can accept a request.
REQ-008 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-009 SHALL have port req_addr  input  MEM_ADDRESS_WIDTH  byte address.
REQ-010 SHALL have port req_wdata  input  DATA_WIDTH  store data, right-aligned.
REQ-011 SHALL have port req_funct3  input  3  RV32I width code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-012 SHALL have port resp_valid  output  1  response available.
REQ-013 SHALL have port resp_ready  input  1  initiator consumes the response.
REQ-014 SHALL have port resp_rdata  output  DATA_WIDTH  extended load data; 0 for stores and errors.
REQ-015 SHALL have port resp_err  output  1  access rejected (see Configuration).

Function
REQ-016 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE.
REQ-017 SHALL drive req_ready = 1 only in IDLE; resp_valid = 1 only in RESP.
REQ-018 SHALL accept a request on the edge where req_valid && req_ready; it SHALL register we/addr/wdata/funct3 and load a counter with LATENCY-1.
REQ-019 In WAIT the counter SHALL decrement each cycle; at zero the FSM SHALL enter RESP on the next edge, so resp_valid rises exactly LATENCY cycles after acceptance (LATENCY = 1: the FSM passes through WAIT for zero cycles, going directly to RESP on the edge following acceptance).
REQ-020 Storage SHALL be byte-addressed and little-endian; the store/load SHALL commit on the edge entering RESP.
REQ-021 Stores SHALL write 1, 2 or 4 bytes from the low bytes of wdata (funct3 000/001/010); other bytes are untouched.
REQ-022 Loads SHALL return sign-extended data for funct3 000/001, zero-extended for 100/101, and the full word for 010.
REQ-023 Funct3 011, 110 and 111 SHALL produce resp_err = 1, resp_rdata = 0 and no write.
REQ-024 resp_valid, resp_rdata and resp_err SHALL stay stable while resp_ready = 0; RESP -> IDLE occurs on the edge with resp_ready = 1.
REQ-025 A request presented while not IDLE SHALL be ignored (req_ready = 0); the initiator holds it.
REQ-026 Addresses whose access would exceed the top byte SHALL wrap modulo 2^MEM_ADDRESS_WIDTH.

Reset
REQ-027 Asserting rst SHALL immediately force IDLE, counter = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0, req_ready = 1 after release.
REQ-028 Reset mid-operation SHALL abandon the pending request with no write; storage contents SHALL NOT be reset.

Configuration
REQ-029 Macro DMEM_MISALIGN_TRAP_EN: when defined, a halfword access with addr[0] = 1 or a word access with addr[1:0] != 0 SHALL give resp_err = 1, resp_rdata = 0 and no write.
REQ-030 Without DMEM_MISALIGN_TRAP_EN, misaligned accesses SHALL be aligned down (addr[0] cleared for H, addr[1:0] cleared for W) and complete with resp_err = 0.

Verification
REQ-031 SW 0xDEADBEEF @0x010, then LW @0x010 -> resp_rdata = 0xDEADBEEF, resp_err = 0, resp_valid exactly LATENCY cycles after each acceptance.
REQ-032 Word 0x000080F0 @0x020; LB @0x020 -> 0xFFFFFFF0; LBU -> 0x000000F0; LH -> 0xFFFF80F0; LHU -> 0x000080F0.
REQ-033 SB 0x12 @0x031 over 0xAABBCCDD @0x030, then LW @0x030 -> 0xAABB12DD.
REQ-034 Hold resp_ready = 0 for 5 cycles -> resp_valid and data stable, req_ready = 0, and a second request is not accepted until the cycle after the resp_ready handshake.
REQ-035 LW @0x012: with the macro -> resp_err = 1, rdata = 0; without -> data from 0x010, resp_err = 0.
REQ-036 Assert rst in WAIT during SW 0x55 @0x040 -> outputs clear asynchronously; a subsequent LW @0x040 returns the prior contents.

Source files
------------

// File: rtl/data_mem_responder.sv
// Byte-addressed little-endian data memory with a fixed-latency valid/ready request/response port.
// Optional macro DMEM_MISALIGN_TRAP_EN: reject misaligned H/W accesses instead of aligning them down.
module data_mem_responder #(
    parameter int DATA_WIDTH        = 32,
    parameter int MEM_ADDRESS_WIDTH = 9,
    parameter int LATENCY           = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_we,
    input  logic [MEM_ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]        req_wdata,
    input  logic [2:0]                   req_funct3,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [DATA_WIDTH-1:0]        resp_rdata,
    output logic                         resp_err
);
    localparam int AW    = MEM_ADDRESS_WIDTH;
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                state_q;
    logic [3:0]            cnt_q;
    logic                  we_q;
    logic [AW-1:0]         addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [2:0]            funct3_q;
    logic                  req_ready_q;
    logic                  resp_valid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    logic [7:0] mem_q [DEPTH];

    logic                  is_h_c, is_w_c, bad_f3_c, err_c, commit_c;
    logic [AW-1:0]         base_c, a0_c, a1_c, a2_c, a3_c;
    logic [7:0]            b0_c, b1_c, b2_c, b3_c;
    logic [DATA_WIDTH-1:0] load_c;

    // 011, 110 and 111 are not RV32I load/store widths
    assign is_h_c   = (funct3_q[1:0] == 2'b01);
    assign is_w_c   = (funct3_q[1:0] == 2'b10);
    assign bad_f3_c = (funct3_q[1:0] == 2'b11) || (funct3_q[2] && funct3_q[1]);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign err_c  = bad_f3_c || (is_h_c && addr_q[0]) || (is_w_c && (addr_q[1:0] != 2'b00));
    assign base_c = addr_q;
`else
    assign err_c  = bad_f3_c;
    always_comb begin
        base_c = addr_q;
        if (is_h_c) base_c[0] = 1'b0;
        if (is_w_c) base_c[1:0] = 2'b00;
    end
`endif

    // Byte lanes wrap naturally in AW-bit arithmetic
    assign a0_c = base_c;
    assign a1_c = base_c + AW'(1);
    assign a2_c = base_c + AW'(2);
    assign a3_c = base_c + AW'(3);
    assign b0_c = mem_q[a0_c];
    assign b1_c = mem_q[a1_c];
    assign b2_c = mem_q[a2_c];
    assign b3_c = mem_q[a3_c];

    always_comb begin
        load_c = '0;
        case (funct3_q)
            3'b000:  load_c = DATA_WIDTH'($signed(b0_c));
            3'b001:  load_c = DATA_WIDTH'($signed({b1_c, b0_c}));
            3'b010:  load_c = DATA_WIDTH'({b3_c, b2_c, b1_c, b0_c});
            3'b100:  load_c = DATA_WIDTH'(b0_c);
            3'b101:  load_c = DATA_WIDTH'({b1_c, b0_c});
            default: load_c = '0;
        endcase
    end

    // The access commits on the edge that moves WAIT -> RESP
    assign commit_c = (state_q == S_WAIT) && (cnt_q == 4'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            funct3_q     <= 3'b000;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q        <= req_we;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        funct3_q    <= req_funct3;
                        cnt_q       <= 4'(LATENCY - 1);
                        req_ready_q <= 1'b0;
                        state_q     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        resp_valid_q <= 1'b1;
                        err_q        <= err_c;
                        rdata_q      <= (err_c || we_q) ? '0 : load_c;
                        state_q      <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        rdata_q      <= '0;
                        err_q        <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Storage is deliberately not reset; commit_c is false while reset holds the FSM in IDLE
    always_ff @(posedge clk) begin
        if (commit_c && we_q && !err_c) begin
            mem_q[a0_c] <= wdata_q[7:0];
            if (is_h_c || is_w_c) mem_q[a1_c] <= wdata_q[15:8];
            if (is_w_c) begin
                mem_q[a2_c] <= wdata_q[23:16];
                mem_q[a3_c] <= wdata_q[31:24];
            end
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: latency, load extension, byte stores, back-pressure, reset abort.
module tb_data_mem_responder;
    localparam int DW  = 32;
    localparam int AW  = 9;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [2:0]    req_funct3 = 3'b000;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;

    int checks = 0;
    int errors = 0;

    data_mem_responder #(.DATA_WIDTH(DW), .MEM_ADDRESS_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_funct3(req_funct3),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present a request and return 1 ns after the accepting edge
    task automatic issue(input string tag, input logic we, input logic [AW-1:0] a,
                         input logic [31:0] d, input logic [2:0] f);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_funct3 = f;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Count edges from acceptance to resp_valid, then check payload
    task automatic resp(input string tag, input logic [31:0] exp_d, input logic exp_e);
        int lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
            if (resp_valid === 1'b1) break;
        end
        chk({tag, "_lat"}, lat, LAT);
        chk({tag, "_data"}, resp_rdata, exp_d);
        chk({tag, "_err"}, {31'b0, resp_err}, {31'b0, exp_e});
    endtask

    task automatic consume(input string tag);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        chk({tag, "_idle"}, {30'b0, resp_valid, req_ready}, 32'd1);
    endtask

    task automatic xfer(input string tag, input logic we, input logic [AW-1:0] a,
                        input logic [31:0] d, input logic [2:0] f,
                        input logic [31:0] exp_d, input logic exp_e);
        issue(tag, we, a, d, f);
        resp(tag, exp_d, exp_e);
        consume(tag);
    endtask

    initial begin
        // Outputs during reset
        #12;
        chk("rst_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", {31'b0, resp_err}, 32'd0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);

        // Word store/load round trip
        xfer("sw10", 1'b1, 9'h010, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0);
        xfer("lw10", 1'b0, 9'h010, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0);

        // Load extension variants
        xfer("sw20", 1'b1, 9'h020, 32'h000080F0, 3'b010, 32'h0, 1'b0);
        xfer("lb20", 1'b0, 9'h020, 32'h0, 3'b000, 32'hFFFFFFF0, 1'b0);
        xfer("lbu20", 1'b0, 9'h020, 32'h0, 3'b100, 32'h000000F0, 1'b0);
        xfer("lh20", 1'b0, 9'h020, 32'h0, 3'b001, 32'hFFFF80F0, 1'b0);
        xfer("lhu20", 1'b0, 9'h020, 32'h0, 3'b101, 32'h000080F0, 1'b0);

        // Partial stores leave neighbouring bytes untouched
        xfer("sw30", 1'b1, 9'h030, 32'hAABBCCDD, 3'b010, 32'h0, 1'b0);
        xfer("sb31", 1'b1, 9'h031, 32'hFFFFFF12, 3'b000, 32'h0, 1'b0);
        xfer("lw30a", 1'b0, 9'h030, 32'h0, 3'b010, 32'hAABB12DD, 1'b0);
        xfer("sh32", 1'b1, 9'h032, 32'h1234BEEF, 3'b001, 32'h0, 1'b0);
        xfer("lw30b", 1'b0, 9'h030, 32'h0, 3'b010, 32'hBEEF12DD, 1'b0);

        // Illegal width codes error out and do not write
        xfer("st011", 1'b1, 9'h030, 32'hFFFFFFFF, 3'b011, 32'h0, 1'b1);
        xfer("ld110", 1'b0, 9'h030, 32'h0, 3'b110, 32'h0, 1'b1);
        xfer("st111", 1'b1, 9'h030, 32'hFFFFFFFF, 3'b111, 32'h0, 1'b1);
        xfer("lw30c", 1'b0, 9'h030, 32'h0, 3'b010, 32'hBEEF12DD, 1'b0);

        // Misaligned accesses
`ifdef DMEM_MISALIGN_TRAP_EN
        xfer("lw12", 1'b0, 9'h012, 32'h0, 3'b010, 32'h0, 1'b1);
        xfer("lh21", 1'b0, 9'h021, 32'h0, 3'b001, 32'h0, 1'b1);
`else
        xfer("lw12", 1'b0, 9'h012, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0);
        xfer("lh21", 1'b0, 9'h021, 32'h0, 3'b001, 32'hFFFF80F0, 1'b0);
`endif

        // Back-pressure: response holds, second request waits for the handshake
        issue("stall", 1'b0, 9'h010, 32'h0, 3'b010);
        resp("stall", 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 9'h020; req_funct3 = 3'b101;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("stall_valid", {31'b0, resp_valid}, 32'd1);
            chk("stall_data", resp_rdata, 32'hDEADBEEF);
            chk("stall_req_ready", {31'b0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        chk("stall_hs_idle", {30'b0, resp_valid, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("stall_2nd_accepted", {31'b0, req_ready}, 32'd0);
        resp("stall2", 32'h000080F0, 1'b0);
        consume("stall2");

        // Reset while waiting abandons the store
        xfer("sw40", 1'b1, 9'h040, 32'h11223344, 3'b010, 32'h0, 1'b0);
        issue("sw40r", 1'b1, 9'h040, 32'h00000055, 3'b010);
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", {31'b0, resp_valid}, 32'd0);
        chk("arst_rdata", resp_rdata, 32'd0);
        chk("arst_err", {31'b0, resp_err}, 32'd0);
        repeat (2) @(posedge clk);
        #1 chk("arst_hold_valid", {31'b0, resp_valid}, 32'd0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        chk("arst_ready", {31'b0, req_ready}, 32'd1);
        xfer("lw40", 1'b0, 9'h040, 32'h0, 3'b010, 32'h11223344, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
